// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_GRANT = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_e;

   localparam int unsigned CNT_W       = $clog2(16);
   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, LS port and shared-memory signals around the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              arb_busy;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, arb_busy
   );

   // Requester / memory side
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, arb_busy
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select between IF and LS.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise LS has fixed priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic    if_req,
   input  logic    ls_req,
   input  req_id_e last_grant,
   output req_id_e winner,
   output logic    any_req
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      any_req = if_req | ls_req;
      winner  = REQ_LS;
      if (if_req && ls_req) begin
         winner = (last_grant == REQ_LS) ? REQ_IF : REQ_LS;
      end else if (if_req) begin
         winner = REQ_IF;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      any_req = if_req | ls_req;
      winner  = ls_req ? REQ_LS : REQ_IF;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Non-pipelined arbiter sharing one fixed-latency single-port memory between IF and LS.
// Optional round-robin arbitration under MEM_ARB_RR_EN (default: fixed LS-over-IF).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 2
) (
   input logic                clk,
   input logic                reset_n,
   mem_port_arbiter_if.slave  bus
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
      $error("mem_port_arbiter: MEM_LAT must be 1..15");
   end

   logic [ST_W-1:0]   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_id_e           winner_q, winner_d;

   logic              if_gnt_q, if_gnt_d;
   logic              ls_gnt_q, ls_gnt_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;

   req_id_e           last_grant;
   req_id_e           pick_winner;
   logic              pick_any;

`ifdef MEM_ARB_RR_EN
   // Remembers which port owned the memory last, for round-robin fairness
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= REQ_IF;
      end else if (state_q == ST_GRANT) begin
         last_grant <= winner_q;
      end
   end
`else
   assign last_grant = REQ_IF;
`endif

   arb_pick u_arb_pick (
      .if_req     (bus.if_req),
      .ls_req     (bus.ls_req),
      .last_grant (last_grant),
      .winner     (pick_winner),
      .any_req    (pick_any)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      winner_d    = winner_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d  = ST_GRANT;
               winner_d = pick_winner;
               mem_en_d = 1'b1;
               if (pick_winner == REQ_LS) begin
                  ls_gnt_d    = 1'b1;
                  mem_we_d    = bus.ls_we;
                  mem_addr_d  = bus.ls_addr;
                  mem_wdata_d = bus.ls_wdata;
               end else begin
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.if_addr;
                  mem_wdata_d = '0;
               end
            end
         end
         ST_GRANT: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Last wait cycle: memory data is valid now
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (winner_q == REQ_LS) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         winner_q    <= REQ_IF;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         winner_q    <= winner_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.ls_gnt    = ls_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.arb_busy  = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1.
// Expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b));

   function automatic logic [63:0] rd(input logic [63:0] addr);
      case (addr)
         64'h10:  return 64'h0000_0000_DEAD_BEEF;
         64'h40:  return 64'h0123_4567_89AB_CDEF;
         default: return ~addr;
      endcase
   endfunction

   // Memory models: data valid exactly MEM_LAT cycles after mem_en, garbage otherwise
   logic [1:0]  pa_v = '0;
   logic [63:0] pa_addr0 = '0, pa_addr1 = '0;
   logic        pb_v = 1'b0;
   logic [63:0] pb_addr = '0;
   always @(posedge clk) begin
      pa_v     <= {pa_v[0], bus_a.mem_en};
      pa_addr0 <= bus_a.mem_addr;
      pa_addr1 <= pa_addr0;
      pb_v     <= bus_b.mem_en;
      pb_addr  <= bus_b.mem_addr;
   end
   assign bus_a.mem_rdata = pa_v[1] ? rd(pa_addr1) : BAD;
   assign bus_b.mem_rdata = pb_v    ? rd(pb_addr)  : BAD;

   // {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, arb_busy}
   logic [6:0] va, vb;
   assign va = {bus_a.if_gnt, bus_a.ls_gnt, bus_a.if_rvalid, bus_a.ls_rvalid,
                bus_a.mem_en, bus_a.mem_we, bus_a.arb_busy};
   assign vb = {bus_b.if_gnt, bus_b.ls_gnt, bus_b.if_rvalid, bus_b.ls_rvalid,
                bus_b.mem_en, bus_b.mem_we, bus_b.arb_busy};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp_a(input string tag, input logic [6:0] exp);
      @(negedge clk);
      check_eq(tag, 64'(va), 64'(exp));
   endtask

   // Expected flags for cycle k of a continuous-request run (requests first seen in cycle 0)
   function automatic logic [6:0] pat(input int k, input int per, input bit rr);
      int a, p;
      bit ls;
      if (k < 1) return 7'b0;
      a  = (k - 1) / per;
      p  = (k - 1) % per;
      ls = rr ? (a % 2 == 0) : 1'b1;
      if (p == 0)       return {!ls, ls, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      if (p == per - 1) return {1'b0, 1'b0, !ls, ls, 1'b0, 1'b0, 1'b0};
      return 7'b0000001;
   endfunction

   initial begin
      reset_n = 1'b0;
      bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.ls_req = 1'b0;
      bus_a.ls_we = 1'b0;  bus_a.ls_addr = '0; bus_a.ls_wdata = '0;
      bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.ls_req = 1'b0;
      bus_b.ls_we = 1'b0;  bus_b.ls_addr = '0; bus_b.ls_wdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_flags_a", 64'(va), 64'd0);
      check_eq("rst_flags_b", 64'(vb), 64'd0);
      check_eq("rst_mem_addr", bus_a.mem_addr, 64'd0);
      check_eq("rst_mem_wdata", bus_a.mem_wdata, 64'd0);
      check_eq("rst_if_rdata", bus_a.if_rdata, 64'd0);
      check_eq("rst_ls_rdata", bus_a.ls_rdata, 64'd0);
      cyc(); reset_n = 1'b1;
      cyc();

      // 1: single IF read, request dropped right after the IDLE sample
      bus_a.if_req = 1'b1; bus_a.if_addr = 64'h10;
      smp_a("t1_c0", 7'b0000000);
      cyc(); bus_a.if_req = 1'b0;
      smp_a("t1_c1", 7'b1000101);
      check_eq("t1_addr_c1", bus_a.mem_addr, 64'h10);
      cyc(); smp_a("t1_c2", 7'b0000001);
      check_eq("t1_addr_c2", bus_a.mem_addr, 64'h10);
      cyc(); smp_a("t1_c3", 7'b0000001);
      cyc(); smp_a("t1_c4", 7'b0010000);
      check_eq("t1_rdata", bus_a.if_rdata, 64'hDEAD_BEEF);
      cyc(); smp_a("t1_c5", 7'b0000000);
      check_eq("t1_rdata_hold", bus_a.if_rdata, 64'hDEAD_BEEF);

      // 2: contention, LS read wins, IF held and served next
      cyc();
      bus_a.if_req = 1'b1; bus_a.if_addr = 64'h80;
      bus_a.ls_req = 1'b1; bus_a.ls_we = 1'b0; bus_a.ls_addr = 64'h40;
      smp_a("t2_c0", 7'b0000000);
      cyc(); bus_a.ls_req = 1'b0;
      smp_a("t2_c1", 7'b0100101);
      check_eq("t2_addr_ls", bus_a.mem_addr, 64'h40);
      cyc(); smp_a("t2_c2", 7'b0000001);
      cyc(); smp_a("t2_c3", 7'b0000001);
      cyc(); smp_a("t2_c4", 7'b0001000);
      check_eq("t2_ls_rdata", bus_a.ls_rdata, 64'h0123_4567_89AB_CDEF);
      cyc(); bus_a.if_req = 1'b0;
      smp_a("t2_c5", 7'b1000101);
      check_eq("t2_addr_if", bus_a.mem_addr, 64'h80);
      cyc(); smp_a("t2_c6", 7'b0000001);
      cyc(); smp_a("t2_c7", 7'b0000001);
      cyc(); smp_a("t2_c8", 7'b0010000);
      check_eq("t2_if_rdata", bus_a.if_rdata, 64'hFFFF_FFFF_FFFF_FF7F);
      check_eq("t2_ls_rdata_hold", bus_a.ls_rdata, 64'h0123_4567_89AB_CDEF);

      // 3: LS write; rdata reported as zero, write fields held through WAIT
      cyc();
      bus_a.ls_req = 1'b1; bus_a.ls_we = 1'b1; bus_a.ls_addr = 64'h20; bus_a.ls_wdata = 64'h55;
      smp_a("t3_c0", 7'b0000000);
      cyc(); bus_a.ls_req = 1'b0; bus_a.ls_we = 1'b0;
      smp_a("t3_c1", 7'b0100111);
      check_eq("t3_wdata_c1", bus_a.mem_wdata, 64'h55);
      check_eq("t3_addr_c1", bus_a.mem_addr, 64'h20);
      cyc(); smp_a("t3_c2", 7'b0000011);
      check_eq("t3_wdata_c2", bus_a.mem_wdata, 64'h55);
      cyc(); smp_a("t3_c3", 7'b0000011);
      check_eq("t3_wdata_c3", bus_a.mem_wdata, 64'h55);
      cyc(); smp_a("t3_c4", 7'b0001010);
      check_eq("t3_ls_rdata", bus_a.ls_rdata, 64'd0);

      // 4: reset asserted mid-WAIT drops the access
      cyc();
      bus_a.if_req = 1'b1; bus_a.if_addr = 64'h10;
      smp_a("t4_c0", 7'b0000010);
      cyc(); bus_a.if_req = 1'b0;
      smp_a("t4_c1", 7'b1000101);
      cyc(); reset_n = 1'b0;
      #1;
      check_eq("t4_async_flags", 64'(va), 64'd0);
      check_eq("t4_async_addr", bus_a.mem_addr, 64'd0);
      check_eq("t4_async_if_rdata", bus_a.if_rdata, 64'd0);
      cyc(); smp_a("t4_c3", 7'b0000000);
      cyc(); reset_n = 1'b1;
      smp_a("t4_c4", 7'b0000000);
      for (int k = 5; k <= 8; k++) begin
         cyc(); smp_a($sformatf("t4_c%0d", k), 7'b0000000);
      end
      check_eq("t4_if_rdata", bus_a.if_rdata, 64'd0);

      // 5: both requests held continuously at MEM_LAT=2
      for (int k = 0; k <= 16; k++) begin
         cyc();
         if (k == 0) begin
            bus_a.if_req = 1'b1; bus_a.if_addr = 64'h80;
            bus_a.ls_req = 1'b1; bus_a.ls_we = 1'b0; bus_a.ls_addr = 64'h40;
         end
         if (k == 16) begin
            bus_a.if_req = 1'b0; bus_a.ls_req = 1'b0;
         end
         smp_a($sformatf("t5_c%0d", k), pat(k, 4, RR));
         if (k == 4) check_eq("t5_ls_rdata", bus_a.ls_rdata, 64'h0123_4567_89AB_CDEF);
      end
      cyc(); smp_a("t5_idle", 7'b0000000);

      // 6: MEM_LAT=1 instance, both requests held continuously
      for (int k = 0; k <= 12; k++) begin
         cyc();
         if (k == 0) begin
            bus_b.if_req = 1'b1; bus_b.if_addr = 64'h80;
            bus_b.ls_req = 1'b1; bus_b.ls_we = 1'b0; bus_b.ls_addr = 64'h40;
         end
         if (k == 12) begin
            bus_b.if_req = 1'b0; bus_b.ls_req = 1'b0;
         end
         @(negedge clk);
         check_eq($sformatf("t6_c%0d", k), 64'(vb), 64'(pat(k, 3, RR)));
         if (k == 3) check_eq("t6_ls_rdata", bus_b.ls_rdata, 64'h0123_4567_89AB_CDEF);
      end
      cyc();
      @(negedge clk);
      check_eq("t6_idle", 64'(vb), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-port memory between the instruction-fetch port (IF) and the load/store port (LS) of the processor.
- Non-pipelined: at most one access is outstanding at a time.
- Each access is a fixed-latency read or write, with registered grant and response handshakes.
- Lets the pipeline use one unified memory in place of separate instruction and data memories.

Parameters:
- ADDR_W, 64, address width of both ports and of the memory.
- DATA_W, 64, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF access request; held until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- ls_req  in  1  LS access request; held until ls_gnt.
- ls_we  in  1  LS write (1) or read (0).
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  LS write data.
- ls_gnt  out  1  one-cycle pulse: LS request accepted.
- ls_rvalid  out  1  one-cycle pulse: LS read data valid, or write complete.
- ls_rdata  out  DATA_W  LS read data; 0 for writes.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en.
- arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state IDLE; counter 0; last-grant = IF. All outputs 0, including mem_addr, mem_wdata and both rdata buses.
- All outputs are registered.

FSM states: IDLE, GRANT, WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests at cycle t:
  - Pick a winner and capture its addr, we and wdata. IF is always a read (we = 0).
  - Move to GRANT.
- GRANT, cycle t+1:
  - Winner's gnt = 1, mem_en = 1.
  - mem_we, mem_addr and mem_wdata driven from the captured registers.
  - Load counter with MEM_LAT; move to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - At cycle t+1+MEM_LAT, sample mem_rdata into the winner's rdata register.
  - Move to IDLE.
- Response, cycle t+2+MEM_LAT:
  - Winner's rvalid = 1 with rdata held. On an LS write, ls_rdata = 0.
  - The FSM is in IDLE in this cycle and samples requests again, so a back-to-back access is granted at t+3+MEM_LAT.
- Access period is MEM_LAT+2 cycles.

Handshake and hold rules:
- mem_addr, mem_we and mem_wdata hold their values through WAIT. mem_en is high only in GRANT.
- rdata registers hold their last value until the next response.
- Requests are ignored outside IDLE.
- A requester deasserting req after the IDLE sample is still serviced: gnt and rvalid are both issued.
- The loser's request stays pending and is re-sampled in the next IDLE.

Priority and reset:
- Default priority is fixed: LS over IF. IF may starve under continuous ls_req; this is accepted.
- reset_n low in any state immediately forces all reset values. The in-flight access is dropped: no rvalid is ever issued for it.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. When both ports request in IDLE, grant the port not granted last. last-grant updates in GRANT. A single requester is always granted.
- Undefined: fixed LS-over-IF priority, and no last-grant register is present.

Decomposition:
- Package mem_arb_pkg:
  - State enum: ST_IDLE, ST_GRANT, ST_WAIT.
  - Requester enum: REQ_IF = 0, REQ_LS = 1.
  - Localparam for counter width: $clog2(16).
- Sub-module arb_pick: combinational winner select.
  - Inputs: if_req, ls_req, last_grant.
  - Outputs: winner, any_req.
  - The round-robin versus fixed selection lives here under MEM_ARB_RR_EN.

Test Plan (MEM_LAT = 2):
1. if_req with if_addr 0x10 at t; memory returns 0xDEADBEEF -> if_gnt and mem_en at t+1 with mem_addr 0x10, mem_we 0; if_rvalid at t+4 with if_rdata 0xDEADBEEF; arb_busy high t+1..t+3.
2. if_req and ls_req (read, 0x40) both at t, fixed priority -> ls_gnt at t+1, ls_rvalid at t+4; if_gnt at t+5, if_rvalid at t+8.
3. LS write at t, addr 0x20, wdata 0x55 -> mem_en and mem_we at t+1 with mem_wdata 0x55, held through t+3; ls_rvalid at t+4 with ls_rdata 0.
4. reset_n low at t+2 during WAIT, released at t+4 -> all outputs 0 asynchronously; no rvalid at any later cycle; arb_busy 0.
5. MEM_ARB_RR_EN defined, both requests held high continuously -> grants alternate LS, IF, LS, IF at t+1, t+5, t+9, t+13.
6. MEM_LAT = 1, ls_req held continuously -> ls_gnt every 3 cycles; if_gnt never asserted without MEM_ARB_RR_EN.
